// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle control FSM: opcodes, branch funct3
// values, ALU operation codes, PC/write-back mux encodings and the FSM state
// type. Imported by the control top and the ALU decoder.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BR) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU operation decoder.
// Ports:
//   opcode, funct3, funct7b5  instruction fields
//   contALU                   ALU operation code
//   illegal_funct             funct combination not supported for this opcode
// Unknown opcodes decode to ADD without flagging; opcode legality is the
// caller's job.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] contALU,
  output logic       illegal_funct
);

  always_comb begin
    contALU       = ALU_ADD;
    illegal_funct = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          3'b000: contALU = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin
            contALU       = ALU_SLL;
            illegal_funct = funct7b5;
          end
          3'b010: contALU = ALU_SLT;
          3'b100: contALU = ALU_XOR;
          3'b101: begin
            contALU       = ALU_SRL;
            illegal_funct = funct7b5;  // SRA / SRAI not supported
          end
          3'b110: contALU = ALU_OR;
          3'b111: contALU = ALU_AND;
          default: illegal_funct = 1'b1;  // SLTU / SLTIU
        endcase
        // For R-type, IR[30] is only meaningful for SUB; for I-type it is an
        // immediate bit except on shifts (handled above).
        if (opcode == OP_R && funct7b5 && funct3 != 3'b000)
          illegal_funct = 1'b1;
      end
      OP_LW, OP_SW: illegal_funct = (funct3 != F3_WORD);
      OP_BR: begin
        contALU       = ALU_SUB;
        illegal_funct = !((funct3 == F3_BEQ) || (funct3 == F3_BNE));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB, driving memory handshake, PC/IR/register-file enables
// and ALU input/operation selects.
// Ports:
//   clk, reset (sync, active high)
//   opcode, funct3, funct7b5    IR fields
//   Znegado                     ALU result non-zero
//   mem_ready / mem_req, mem_we, mem_is_instr   memory handshake
//   ir_we, pc_we, pc_sel, reg_we, sel_wb         datapath enables / muxes
//   selALU_JAL, selALU_src, contALU              ALU controls
//   illegal, mem_timeout                         sticky error flags
//
// state  | meaning
// FETCH  | request instruction at PC; latch IR and PC+4 on mem_ready
// DECODE | register file reads settle; illegal encodings go to HALT
// EXEC   | ALU operation; branches and JAL update PC here
// MEM    | data access at resALU; store or load
// WB     | register file write
// HALT   | stopped after an error; left only through reset
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Znegado,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_instr,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] sel_wb,
  output logic       selALU_JAL,
  output logic       selALU_src,
  output logic [2:0] contALU,
  output logic       illegal,
  output logic       mem_timeout
);

  // Wait budget is a down-counter loaded on every state entry; hitting zero
  // while still waiting means MEM_WAIT_MAX request cycles went unanswered.
  localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam bit WAIT_CHECK = (MEM_WAIT_MAX > 0);
  localparam logic [WW-1:0] WAIT_LOAD = WAIT_CHECK ? WW'(MEM_WAIT_MAX - 1) : '0;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;

  logic       mem_req_c, mem_we_c, mem_is_instr_c, ir_we_c, pc_we_c, reg_we_c;
  logic       sel_jal_c, sel_src_c;
  logic [1:0] pc_sel_c, sel_wb_c;
  logic [2:0] alu_c, dec_alu;
  logic       dec_illegal;
  logic       taken;

  multicycle_control_alu_decoder u_alu_decoder (
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .contALU      (dec_alu),
    .illegal_funct(dec_illegal)
  );

  assign taken = ((funct3 == F3_BEQ) && !Znegado) || ((funct3 == F3_BNE) && Znegado);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= WAIT_LOAD;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    illegal_d      = illegal_q;
    timeout_d      = timeout_q;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_is_instr_c = 1'b0;
    ir_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_sel_c       = PC_SEL_PC4;
    reg_we_c       = 1'b0;
    sel_wb_c       = WB_ALU;
    sel_jal_c      = 1'b0;
    sel_src_c      = 1'b0;
    alu_c          = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        mem_req_c      = 1'b1;
        mem_is_instr_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_DECODE;
        end else if (WAIT_CHECK && wait_q == '0) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end else if (WAIT_CHECK) begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_DECODE: begin
        if (!is_supported_op(opcode) || dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_c     = dec_alu;
        sel_jal_c = (opcode == OP_JAL);
        sel_src_c = (opcode != OP_R) && (opcode != OP_BR);
        case (opcode)
          OP_BR: begin
            pc_we_c  = taken;
            pc_sel_c = taken ? PC_SEL_BR : PC_SEL_PC4;
            state_d  = ST_FETCH;
          end
          OP_LW, OP_SW: state_d = ST_MEM;
          OP_JAL: begin
            pc_we_c  = 1'b1;
            pc_sel_c = PC_SEL_ALU;
            state_d  = ST_WB;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (opcode == OP_SW);
        if (mem_ready) begin
          state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
        end else if (WAIT_CHECK && wait_q == '0) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end else if (WAIT_CHECK) begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_WB: begin
        reg_we_c = 1'b1;
        sel_wb_c = (opcode == OP_LW) ? WB_MEM : (opcode == OP_JAL) ? WB_LINK : WB_ALU;
        state_d  = ST_FETCH;
      end
      default: ;
    endcase
    if (state_d != state_q)
      wait_d = WAIT_LOAD;
  end

  // Outputs are forced low during the reset cycle so an access in flight is
  // dropped immediately rather than one cycle later.
  assign mem_req      = mem_req_c      & ~reset;
  assign mem_we       = mem_we_c       & ~reset;
  assign mem_is_instr = mem_is_instr_c & ~reset;
  assign ir_we        = ir_we_c        & ~reset;
  assign pc_we        = pc_we_c        & ~reset;
  assign reg_we       = reg_we_c       & ~reset;
  assign selALU_JAL   = sel_jal_c      & ~reset;
  assign selALU_src   = sel_src_c      & ~reset;
  assign pc_sel       = reset ? 2'b00 : pc_sel_c;
  assign sel_wb       = reset ? 2'b00 : sel_wb_c;
  assign contALU      = reset ? 3'b000 : alu_c;
  assign illegal      = illegal_q      & ~reset;
  assign mem_timeout  = timeout_q      & ~reset;

endmodule
